data_memory_mmio: RTL and testbench
===================================

# data_memory_mmio

Data-side memory responder for the pipelined core: it answers the core's memory-stage port (MemWriteM, ALUOutM, WriteDataM, ReadDataM) with a word RAM plus a small memory-mapped I/O window. The window holds a free-running cycle counter, a byte output FIFO drained by a host over a valid/ready port, and a status register. It sits beside the core at top level, on the opposite end of the core's data interface.

## Interface
- DEPTH_WORDS, 1024: RAM size in 32-bit words, power of two.
- FIFO_DEPTH, 8: output FIFO entries, power of two, ≥2.
- MMIO_BASE, 32'hFFFF_0000: base address of the I/O window.

- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- MemWriteM  in  1  write strobe from the core's M stage.
- ALUOutM  in  32  byte address from the core.
- WriteDataM  in  32  store data.
- ReadDataM  out  32  load data, combinational from ALUOutM and current state.
- tx_valid  out  1  FIFO head valid (FIFO not empty).
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  host accepts head this cycle.

## Operation
- **Decode:**
  - RAM hit when ALUOutM < DEPTH_WORDS*4. Word index = ALUOutM[log2(DEPTH_WORDS)+1:2]; bits [1:0] are ignored.
  - MMIO registers:
    - MMIO_BASE+0 CYCLE (RO).
    - MMIO_BASE+4 TXDATA (WO).
    - MMIO_BASE+8 STATUS (R, write-to-clear).
  - Any other address is unmapped: reads return 0, writes have no effect.
- **RAM:**
  - Asynchronous read; write on the rising edge when MemWriteM=1.
  - RAM is not cleared by reset. Contents are X until written.
- **CYCLE:**
  - 32-bit counter, incremented every cycle out of reset, wraps 0xFFFF_FFFF→0.
  - Writes are ignored. Reads return the current registered value.
- **TXDATA:**
  - A write pushes WriteDataM[7:0] into the FIFO.
  - Reads of TXDATA return 0.
- **STATUS read:**
  - [0] empty, [1] full, [2] overflow sticky.
  - [15:8] occupancy count, zero-extended.
  - All other bits 0.
- **STATUS write** (any data): clears overflow.
- **FIFO:**
  - Circular buffer with read and write pointers plus a count register. Pointers wrap modulo FIFO_DEPTH.
  - Pop happens when tx_valid && tx_ready.
  - Push happens on a TXDATA write when the FIFO is not full, or when it is full but a pop occurs in the same cycle.
  - A push while full with no pop drops the byte and sets overflow. Occupancy is unchanged.
  - Simultaneous push and pop: both are performed and count is unchanged; this holds at any occupancy, including full.
  - Push into an empty FIFO: tx_valid rises the following cycle. There is no fall-through.
  - tx_data = head entry. tx_data is undefined when tx_valid=0, and the bench must not check it then.
- **Overflow sticky:**
  - Set on a dropped push; cleared by a STATUS write or by reset.
  - If a set and a clear occur in the same cycle, set wins.

## Timing
- **Reset (asynchronous, immediate):**
  - CYCLE=0, FIFO pointers and count=0, overflow=0.
  - tx_valid=0, tx_data=0.
  - ReadDataM reflects the reset state combinationally; for example, a STATUS read returns 0x0000_0001.
- **Load latency:** zero cycles. ReadDataM is valid in the same cycle as ALUOutM, matching the core's single-cycle M stage.
- **Store effect:** RAM, FIFO and STATUS updates take effect at the clock edge ending the store cycle.
- **Same-cycle store+load, same RAM word:** returns the old data.
- **Reset asserted mid-drain:** the FIFO empties at once and tx_valid drops asynchronously. The host must treat this as discarded data.
- **CYCLE read in cycle n after reset release:** returns n, where the first post-reset cycle is n=0.

## Test plan
- **RAM round-trip:** write 0xDEAD_BEEF to 0x10, 0x1234_5678 to 0x13 (same word index 4) → a read at 0x10 returns 0x1234_5678; a read at 0x40 (never written) is not checked.
- **Unmapped access:** write to MMIO_BASE+0xC, read MMIO_BASE+0xC and DEPTH_WORDS*4 → ReadDataM=0; RAM and FIFO unchanged.
- **Counter:**
  - Release reset, read CYCLE at post-reset cycles 0, 5 and 100 → 0, 5, 100.
  - Force the counter near wrap in simulation: 0xFFFF_FFFF → next cycle 0.
- **FIFO fill/overflow:**
  - tx_ready=0; push 0x41..0x48 (8 bytes) → STATUS=0x0000_0802 (count 8, full).
  - Ninth push 0x49 → STATUS=0x0000_0806, 0x49 lost.
  - Write STATUS → overflow cleared, STATUS=0x0000_0802.
- **Drain and concurrency:**
  - From full, tx_ready=1 for 8 cycles → tx_data sequence 0x41..0x48, then tx_valid=0, STATUS=0x0000_0001.
  - Second case: full FIFO, tx_ready=1 with a same-cycle push of 0x50 → count stays 8, no overflow, 0x50 emerges last.
- **Reset mid-operation:** 3 bytes queued, assert reset asynchronously between edges → tx_valid=0 immediately; after release STATUS=0x0000_0001 and CYCLE restarts at 0.

Source files
------------

// File: rtl/data_memory_mmio_if.sv
//------------------------------------------------------------------------------
// Module      : data_memory_mmio_if
// Description : Core memory-stage port plus host byte-stream port for the data
//               memory responder.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface data_memory_mmio_if;
    logic        MemWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    // The core drives the M-stage request and the host drives tx_ready.
    modport master (
        output MemWriteM,
        output ALUOutM,
        output WriteDataM,
        output tx_ready,
        input  ReadDataM,
        input  tx_valid,
        input  tx_data
    );

    modport slave (
        input  MemWriteM,
        input  ALUOutM,
        input  WriteDataM,
        input  tx_ready,
        output ReadDataM,
        output tx_valid,
        output tx_data
    );
endinterface

`default_nettype wire

// File: rtl/data_memory_mmio.sv
//------------------------------------------------------------------------------
// Module      : data_memory_mmio
// Description : Word RAM plus MMIO window (cycle counter, byte TX FIFO, status)
//               answering the core's memory stage with zero-latency loads.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module data_memory_mmio #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    data_memory_mmio_if.slave     bus
);

    localparam int          c_AW          = $clog2(DEPTH_WORDS);
    localparam int          c_PW          = $clog2(FIFO_DEPTH);
    localparam int          c_CW          = c_PW + 1;
    localparam logic [31:0] c_RAM_BYTES   = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] c_ADDR_CYCLE  = MMIO_BASE;
    localparam logic [31:0] c_ADDR_TXDATA = MMIO_BASE + 32'd4;
    localparam logic [31:0] c_ADDR_STATUS = MMIO_BASE + 32'd8;
    localparam logic [c_CW-1:0] c_FULL    = c_CW'(FIFO_DEPTH);

    logic [31:0]      r_ram  [DEPTH_WORDS];
    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             r_ovf;
    logic [31:0]      r_cycle;

    logic             w_ram_hit;
    logic [c_AW-1:0]  w_idx;
    logic             w_sel_cycle;
    logic             w_sel_txdata;
    logic             w_sel_status;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic             w_drop;
    logic             w_clr;
    logic [31:0]      w_status;
    logic [31:0]      w_rdata;

    // Address decode
    assign w_ram_hit    = (bus.ALUOutM < c_RAM_BYTES);
    assign w_idx        = bus.ALUOutM[c_AW+1:2];
    assign w_sel_cycle  = (bus.ALUOutM == c_ADDR_CYCLE);
    assign w_sel_txdata = (bus.ALUOutM == c_ADDR_TXDATA);
    assign w_sel_status = (bus.ALUOutM == c_ADDR_STATUS);

    // FIFO control: a pop frees a slot in the same cycle, so a full FIFO
    // can still accept a push when the host drains concurrently.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = !w_empty && bus.tx_ready;
    assign w_push_req = bus.MemWriteM && w_sel_txdata;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;
    assign w_clr      = bus.MemWriteM && w_sel_status;

    assign w_status = {16'h0000, 8'(r_count), 5'b00000, r_ovf, w_full, w_empty};

    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_ram_hit) begin
            w_rdata = r_ram[w_idx];
        end else if (w_sel_cycle) begin
            w_rdata = r_cycle;
        end else if (w_sel_status) begin
            w_rdata = w_status;
        end
    end

    assign bus.ReadDataM = w_rdata;
    assign bus.tx_valid  = !w_empty;
    assign bus.tx_data   = w_empty ? 8'h00 : r_fifo[r_rd_ptr];

    // Storage arrays carry no reset; their contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (bus.MemWriteM && w_ram_hit) begin
            r_ram[w_idx] <= bus.WriteDataM;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus.WriteDataM[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as a STATUS write leaves overflow set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle <= 32'h0000_0000;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_memory_mmio.sv
//------------------------------------------------------------------------------
// Module      : tb_data_memory_mmio
// Description : Directed plus randomized bench for data_memory_mmio against a
//               queue/array reference model.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_data_memory_mmio;

    localparam int          DW   = 1024;
    localparam int          FD   = 8;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    data_memory_mmio_if bus ();

    data_memory_mmio #(
        .DEPTH_WORDS (DW),
        .FIFO_DEPTH  (FD),
        .MMIO_BASE   (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [31:0] m_ram [DW];
    bit          m_ok  [DW];
    logic [7:0]  m_q   [$];
    bit          m_ovf;
    logic [31:0] m_cyc;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] o_rd;
    logic [7:0]  o_td;
    logic        o_tv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
        int n;
        n = m_q.size();
        v = 32'h0;
        if (a < DW * 4) begin
            v = m_ram[a >> 2];
            return m_ok[a >> 2];
        end
        if (a == BASE)         v = m_cyc;
        else if (a == BASE + 8) v = (n << 8) | (m_ovf << 2) | ((n == FD) << 1) | (n == 0);
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf = 1'b0;
        m_cyc = 32'h0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d, input bit rdy);
        logic [31:0] exp;
        bit          pop;
        bit          full;
        bus.MemWriteM  = we;
        bus.ALUOutM    = a;
        bus.WriteDataM = d;
        bus.tx_ready   = rdy;
        #1;
        o_rd = bus.ReadDataM;
        o_td = bus.tx_data;
        o_tv = bus.tx_valid;
        if (model_read(a, exp)) chk("rdata", o_rd, exp);
        chk("tx_valid", {31'h0, o_tv}, {31'h0, m_q.size() != 0});
        if (m_q.size() != 0) chk("tx_data", {24'h0, o_td}, {24'h0, m_q[0]});
        @(posedge clk);
        pop  = (m_q.size() != 0) && rdy;
        full = (m_q.size() == FD);
        if (pop) void'(m_q.pop_front());
        if (we && a < DW * 4) begin
            m_ram[a >> 2] = d;
            m_ok[a >> 2]  = 1'b1;
        end
        if (we && a == BASE + 4) begin
            if (!full || pop) m_q.push_back(d[7:0]);
            else              m_ovf = 1'b1;
        end
        if (we && a == BASE + 8) m_ovf = 1'b0;
        m_cyc = m_cyc + 32'd1;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        bus.MemWriteM  = 1'b0;
        bus.ALUOutM    = BASE + 8;
        bus.WriteDataM = 32'h0;
        bus.tx_ready   = 1'b0;
        for (int i = 0; i < DW; i++) m_ok[i] = 1'b0;
        model_reset();

        // Asynchronous reset before the first clock edge
        #1 reset = 1'b1;
        #2;
        chk("rst_status", bus.ReadDataM, 32'h0000_0001);
        chk("rst_tv", {31'h0, bus.tx_valid}, 32'h0);
        chk("rst_td", {24'h0, bus.tx_data}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Cycle counter from release
        step(0, BASE, 0, 0); chk("cyc0", o_rd, 32'd0);
        for (int i = 1; i < 5; i++) step(0, BASE, 0, 0);
        step(0, BASE, 0, 0); chk("cyc5", o_rd, 32'd5);
        for (int i = 6; i < 100; i++) step(0, BASE, 0, 0);
        step(0, BASE, 0, 0); chk("cyc100", o_rd, 32'd100);

        // Counter wrap
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1 release dut.r_cycle;
        m_cyc = 32'hFFFF_FFFF;
        step(0, BASE, 0, 0); chk("cyc_max", o_rd, 32'hFFFF_FFFF);
        step(0, BASE, 0, 0); chk("cyc_wrap", o_rd, 32'h0);

        // RAM round trip and same-cycle store+load
        step(1, 32'h10, 32'hDEAD_BEEF, 0);
        step(1, 32'h13, 32'h1234_5678, 0);
        step(0, 32'h10, 0, 0);            chk("ram_rt", o_rd, 32'h1234_5678);
        step(1, 32'h10, 32'hCAFE_F00D, 0); chk("ram_old", o_rd, 32'h1234_5678);
        step(0, 32'h12, 0, 0);            chk("ram_new", o_rd, 32'hCAFE_F00D);

        // Unmapped accesses
        step(1, BASE + 12, 32'hFFFF_FFFF, 0);
        step(0, BASE + 12, 0, 0);  chk("unmap_mmio", o_rd, 32'h0);
        step(0, DW * 4, 0, 0);     chk("unmap_ram", o_rd, 32'h0);
        step(0, BASE + 4, 0, 0);   chk("txdata_rd", o_rd, 32'h0);
        step(0, BASE + 8, 0, 0);   chk("unmap_status", o_rd, 32'h1);

        // Fill, overflow, clear
        for (int i = 0; i < 8; i++) step(1, BASE + 4, 32'h41 + i, 0);
        step(0, BASE + 8, 0, 0);   chk("full", o_rd, 32'h0000_0802);
        step(1, BASE + 4, 32'h49, 0);
        step(0, BASE + 8, 0, 0);   chk("ovf", o_rd, 32'h0000_0806);
        step(1, BASE + 8, 0, 0);
        step(0, BASE + 8, 0, 0);   chk("ovf_clr", o_rd, 32'h0000_0802);

        // Drain
        for (int i = 0; i < 8; i++) begin
            step(0, BASE + 8, 0, 1);
            chk("drain", {24'h0, o_td}, 32'h41 + i);
        end
        step(0, BASE + 8, 0, 0);
        chk("drain_tv", {31'h0, o_tv}, 32'h0);
        chk("drain_status", o_rd, 32'h0000_0001);

        // Push and pop together while full
        for (int i = 0; i < 8; i++) step(1, BASE + 4, 32'h41 + i, 0);
        step(1, BASE + 4, 32'h50, 1);
        step(0, BASE + 8, 0, 0);   chk("pp_full", o_rd, 32'h0000_0802);
        for (int i = 0; i < 8; i++) step(0, BASE + 8, 0, 1);
        chk("pp_last", {24'h0, o_td}, 32'h50);

        // Reset between edges with data queued
        for (int i = 0; i < 3; i++) step(1, BASE + 4, 32'h60 + i, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_tv", {31'h0, bus.tx_valid}, 32'h0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, BASE, 0, 0);       chk("rst_cyc0", o_rd, 32'h0);
        step(0, BASE + 8, 0, 0);   chk("rst_status2", o_rd, 32'h0000_0001);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: a = 32'($urandom_range(0, 255));
                3:       a = BASE;
                4, 5:    a = BASE + 4;
                6:       a = BASE + 8;
                default: begin
                    case ($urandom_range(0, 3))
                        0:       a = BASE + 12;
                        1:       a = DW * 4;
                        2:       a = DW * 4 - 4;
                        default: a = 32'h8000_0000;
                    endcase
                end
            endcase
            step(1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
